// File: rtl/bp_pkg.sv
// Shared types for the two-bit branch predictor: counter encoding, in-flight entry
// layout and the saturating counter helpers.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  // Widest BHT index an entry can carry; the top level uses the low IDX_BITS.
  localparam int IDX_W_MAX = 16;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    logic                 predicted;
    logic [31:0]          jump_addr;
    logic [31:0]          next_addr;
  } pend_entry_t;

  function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
    logic [2:0] ext;
    ext = {1'b0, c};
    if (taken) ext = (ext == 3'd3) ? 3'd3 : ext + 3'd1;
    else       ext = (ext == 3'd0) ? 3'd0 : ext - 3'd1;
    return ctr_t'(ext[1:0]);
  endfunction

  function automatic logic ctr_taken(input ctr_t c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/bp_pending_fifo.sv
// Circular queue of in-flight branch entries with push, pop, clear, count and full.
// DEPTH must be a power of two so the pointers wrap on their own.
module bp_pending_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  pend_entry_t                push_data,
  output pend_entry_t                head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  pend_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[head];
  assign do_push   = en && push && !full && !clear;
  assign do_pop    = en && pop && !empty && !clear;

  // Clear dominates: a flush throws away every in-flight branch at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (en) begin
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + PTR_W'(1);
        if (do_pop)  head <= head + PTR_W'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/bht_predictor.sv
// Two-bit BHT branch predictor with an in-flight queue, flush pulses and IF redirect.
// Define BHT_GSHARE_EN to XOR a global history register into the table index.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS   = 6,
  parameter int PEND_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ask_predictor,
  input  logic [31:0] now_ins_addr,
  input  logic [31:0] jump_addr_from_if,
  input  logic [31:0] next_addr_from_if,
  output logic        jump,
  output logic        predictor_sgn_rdy,
  output logic        predictor_full,
  output logic        if_flush,
  output logic        lsb_flush,
  output logic        rob_flush,
  output logic        rs_flush,
  output logic        register_flush,
  output logic        cdb_flush,
  output logic [31:0] addr_to_if,
  input  logic        branch_commit,
  input  logic        branch_jump
);

  localparam int NUM_CTR = 1 << IDX_BITS;

  ctr_t                     bht [NUM_CTR];
  logic [IDX_BITS-1:0]      pc_idx;
  logic [IDX_BITS-1:0]      q_idx;
  logic [IDX_BITS-1:0]      head_idx;
  pend_entry_t              head;
  pend_entry_t              push_entry;
  logic [$clog2(PEND_DEPTH):0] pend_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     commit_ok;
  logic                     mispredict;
  logic                     query_ok;
  logic                     q_pred;
  logic                     flush_q;
  logic                     unused_bits;

  assign pc_idx = now_ins_addr[IDX_BITS+1:2];

`ifdef BHT_GSHARE_EN
  logic [IDX_BITS-1:0] ghr;

  assign q_idx = pc_idx ^ ghr;

  // History advances on every accepted commit, mispredicted or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   ghr <= '0;
    else if (rdy && commit_ok) ghr <= {ghr[IDX_BITS-2:0], branch_jump};
  end
`else
  assign q_idx = pc_idx;
`endif

  assign head_idx   = head.idx[IDX_BITS-1:0];
  assign commit_ok  = branch_commit && !fifo_empty;
  assign mispredict = commit_ok && (head.predicted != branch_jump);
  assign query_ok   = ask_predictor && !fifo_full && !mispredict;
  assign q_pred     = ctr_taken(bht[q_idx]);

  assign predictor_full = fifo_full;
  assign unused_bits    = ^{head, now_ins_addr, pend_count};

  always_comb begin
    push_entry                    = '0;
    push_entry.idx[IDX_BITS-1:0]  = q_idx;
    push_entry.predicted          = q_pred;
    push_entry.jump_addr          = jump_addr_from_if;
    push_entry.next_addr          = next_addr_from_if;
  end

  bp_pending_fifo #(
    .DEPTH(PEND_DEPTH)
  ) u_pending (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .push      (query_ok),
    .pop       (commit_ok),
    .clear     (mispredict),
    .push_data (push_entry),
    .head_data (head),
    .count     (pend_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The query reads the table combinationally, so a same-cycle update to the
  // same counter is not visible to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTR; i++) bht[i] <= WNT;
    end else if (rdy && commit_ok) begin
      bht[head_idx] <= ctr_update(bht[head_idx], branch_jump);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      predictor_sgn_rdy <= 1'b0;
      jump              <= 1'b0;
      flush_q           <= 1'b0;
      addr_to_if        <= '0;
    end else if (rdy) begin
      predictor_sgn_rdy <= query_ok;
      flush_q           <= mispredict;
      if (query_ok)   jump       <= q_pred;
      if (mispredict) addr_to_if <= branch_jump ? head.jump_addr : head.next_addr;
    end
  end

  assign if_flush       = flush_q;
  assign lsb_flush      = flush_q;
  assign rob_flush      = flush_q;
  assign rs_flush       = flush_q;
  assign register_flush = flush_q;
  assign cdb_flush      = flush_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed test-plan cases plus randomized
// traffic, all checked against a queue/array model of the predictor.
module tb_bht_predictor;

  localparam int IDX_BITS = 6;
  localparam int DEPTH    = 8;
  localparam int NUM_CTR  = 1 << IDX_BITS;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ask_predictor;
  logic [31:0] now_ins_addr;
  logic [31:0] jump_addr_from_if;
  logic [31:0] next_addr_from_if;
  logic        jump;
  logic        predictor_sgn_rdy;
  logic        predictor_full;
  logic        if_flush, lsb_flush, rob_flush, rs_flush, register_flush, cdb_flush;
  logic [31:0] addr_to_if;
  logic        branch_commit;
  logic        branch_jump;

  bht_predictor #(.IDX_BITS(IDX_BITS), .PEND_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .ask_predictor     (ask_predictor),
    .now_ins_addr      (now_ins_addr),
    .jump_addr_from_if (jump_addr_from_if),
    .next_addr_from_if (next_addr_from_if),
    .jump              (jump),
    .predictor_sgn_rdy (predictor_sgn_rdy),
    .predictor_full    (predictor_full),
    .if_flush          (if_flush),
    .lsb_flush         (lsb_flush),
    .rob_flush         (rob_flush),
    .rs_flush          (rs_flush),
    .register_flush    (register_flush),
    .cdb_flush         (cdb_flush),
    .addr_to_if        (addr_to_if),
    .branch_commit     (branch_commit),
    .branch_jump       (branch_jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          pred;
    logic [31:0] ja;
    logic [31:0] na;
  } m_entry_t;

  m_entry_t    mq[$];
  int          mbht [NUM_CTR];
  int          mghr;
  bit          exp_rdy;
  bit          exp_jump;
  bit          exp_flush;
  logic [31:0] exp_addr;
  int          checks;
  int          errors;
  logic        pred_seen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) & 32'(NUM_CTR - 1));
`ifdef BHT_GSHARE_EN
    i = i ^ mghr;
`endif
    return i;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NUM_CTR; i++) mbht[i] = 1;
    mghr      = 0;
    exp_rdy   = 0;
    exp_jump  = 0;
    exp_flush = 0;
    exp_addr  = '0;
  endtask

  // Model of one clock edge: what the outputs must show right after it.
  task automatic model_step(input bit a, input logic [31:0] pc, input logic [31:0] ja,
                            input logic [31:0] na, input bit c, input bit bj, input bit r);
    bit       commit_v, mis, qry, pred;
    int       qi;
    m_entry_t h;
    if (!r) return;
    commit_v = c && (mq.size() > 0);
    mis      = commit_v && (mq[0].pred != bj);
    qi       = m_idx(pc);
    pred     = (mbht[qi] >= 2);
    qry      = a && (mq.size() < DEPTH) && !mis;
    if (commit_v) begin
      h = mq.pop_front();
      if (bj) mbht[h.idx] = (mbht[h.idx] == 3) ? 3 : mbht[h.idx] + 1;
      else    mbht[h.idx] = (mbht[h.idx] == 0) ? 0 : mbht[h.idx] - 1;
      mghr = ((mghr << 1) | int'(bj)) & (NUM_CTR - 1);
    end
    exp_flush = mis;
    if (mis) begin
      mq.delete();
      exp_addr = bj ? h.ja : h.na;
    end
    exp_rdy = qry;
    if (qry) begin
      mq.push_back('{idx: qi, pred: pred, ja: ja, na: na});
      exp_jump = pred;
    end
  endtask

  task automatic applyStimulus(input bit a, input logic [31:0] pc, input logic [31:0] ja,
                               input logic [31:0] na, input bit c, input bit bj, input bit r);
    @(negedge clk);
    ask_predictor     = a;
    now_ins_addr      = pc;
    jump_addr_from_if = ja;
    next_addr_from_if = na;
    branch_commit     = c;
    branch_jump       = bj;
    rdy               = r;
    model_step(a, pc, ja, na, c, bj, r);
    @(posedge clk);
    #2;
  endtask

  task automatic query(input logic [31:0] pc);
    applyStimulus(1'b1, pc, pc + 32'h40, pc + 32'd4, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic commit(input bit bj);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, bj, 1'b1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic doReset();
    @(negedge clk);
    ask_predictor = 1'b0;
    branch_commit = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checkOutput("async_rst_flush", {if_flush, lsb_flush, rob_flush, rs_flush, register_flush, cdb_flush}, 32'h0);
    checkOutput("async_rst_sgn_rdy", predictor_sgn_rdy, 32'h0);
    checkOutput("async_rst_addr", addr_to_if, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    checkOutput("sgn_rdy", predictor_sgn_rdy, 32'(exp_rdy));
    checkOutput("full", predictor_full, 32'(mq.size() == DEPTH));
    checkOutput("flush_all", {if_flush, lsb_flush, rob_flush, rs_flush, register_flush, cdb_flush},
                exp_flush ? 32'h3f : 32'h0);
    if (exp_rdy)   checkOutput("jump", jump, 32'(exp_jump));
    if (exp_flush) checkOutput("addr_to_if", addr_to_if, exp_addr);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rdy = 1'b1;
    ask_predictor = 1'b0;
    now_ins_addr = '0;
    jump_addr_from_if = '0;
    next_addr_from_if = '0;
    branch_commit = 1'b0;
    branch_jump = 1'b0;
    model_reset();
    #1;
    checkOutput("reset_sgn_rdy", predictor_sgn_rdy, 32'h0);
    checkOutput("reset_jump", jump, 32'h0);
    checkOutput("reset_flush", {if_flush, lsb_flush, rob_flush, rs_flush, register_flush, cdb_flush}, 32'h0);
    checkOutput("reset_addr", addr_to_if, 32'h0);
    checkOutput("reset_full", predictor_full, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] cold query and training");
    query(32'h100);
    checkOutput("cold_sgn_rdy", predictor_sgn_rdy, 32'h1);
    checkOutput("cold_jump", jump, 32'h0);
    checkOutput("cold_full", predictor_full, 32'h0);
    commit(1'b1);
    query(32'h100);
    commit(1'b1);
    query(32'h100);
    checkOutput("third_query_jump", jump, 32'h1);
    commit(1'b1);
    query(32'h100);
    commit(1'b1);
    for (int k = 0; k < 2; k++) begin
      query(32'h100);
      commit(1'b0);
    end
    query(32'h100);
    checkOutput("detrained_jump", jump, 32'h0);
    commit(1'b0);

    $display("[TB] mispredict redirect");
    applyStimulus(1'b1, 32'h200, 32'h300, 32'h204, 1'b0, 1'b0, 1'b1);
    checkOutput("redir_pred", jump, 32'h0);
    commit(1'b1);
    checkOutput("redir_flush", {if_flush, lsb_flush, rob_flush, rs_flush, register_flush, cdb_flush}, 32'h3f);
    checkOutput("redir_addr", addr_to_if, 32'h300);
    idle();
    checkOutput("redir_flush_off", if_flush, 32'h0);
    checkOutput("redir_full_off", predictor_full, 32'h0);

    $display("[TB] fill, full and simultaneous events");
    for (int k = 0; k < DEPTH; k++) query(32'h400 + 32'(4 * k));
    checkOutput("fill_full", predictor_full, 32'h1);
    query(32'h500);
    checkOutput("ninth_sgn_rdy", predictor_sgn_rdy, 32'h0);
    applyStimulus(1'b1, 32'h500, 32'h540, 32'h504, 1'b1, 1'b0, 1'b1);
    checkOutput("full_qc_sgn_rdy", predictor_sgn_rdy, 32'h0);
    checkOutput("full_qc_full", predictor_full, 32'h0);
    applyStimulus(1'b1, 32'h440, 32'h480, 32'h444, 1'b1, 1'b0, 1'b1);
    checkOutput("simul_sgn_rdy", predictor_sgn_rdy, 32'h1);
    checkOutput("simul_full", predictor_full, 32'h0);
    query(32'h448);
    checkOutput("simul_count_kept", predictor_full, 32'h1);
    applyStimulus(1'b1, 32'h44c, 32'h48c, 32'h450, 1'b1, 1'b1, 1'b1);
    checkOutput("mis_q_sgn_rdy", predictor_sgn_rdy, 32'h0);
    checkOutput("mis_q_flush", if_flush, 32'h1);
    checkOutput("mis_q_addr", addr_to_if, 32'h448);
    checkOutput("mis_q_full", predictor_full, 32'h0);
    commit(1'b1);
    checkOutput("empty_commit_flush", if_flush, 32'h0);

    $display("[TB] stall during flush");
    query(32'h600);
    commit(!mq[0].pred);
    checkOutput("stall_flush_on", cdb_flush, 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h604, 32'h700, 32'h608, 1'b1, 1'b0, 1'b0);
      checkOutput("stall_flush_held", cdb_flush, 32'h1);
    end
    idle();
    checkOutput("stall_flush_done", cdb_flush, 32'h0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) == 0) ? 32'h1100 : 32'h1000 + 32'(4 * $urandom_range(0, 15));
      applyStimulus($urandom_range(0, 99) < 60, pc, $urandom, pc + 32'd4,
                    $urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 99) < 90);
      if (n == 300) begin
        doReset();
        checkOutput("midrun_reset_full", predictor_full, 32'h0);
        query(32'h100);
        pred_seen = jump;
        checkOutput("midrun_reset_cold_jump", pred_seen, 32'h0);
      end
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
